// File: rtl/sequencer_pkg.sv
// rtl/sequencer_pkg.sv - shared types and constants for the milestone sequencer
package sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_START,
        SEQ_RUN,
        SEQ_GAP,
        SEQ_DONE
    } seq_state_type;

    localparam int N_STAGES_DEFAULT = 4;
    localparam int SRAM_ADDR_W      = 18;
    localparam int SRAM_DATA_W      = 16;

    localparam logic [SRAM_ADDR_W-1:0] PARK_ADDR = '0;
    localparam logic [SRAM_DATA_W-1:0] PARK_DATA = '0;

    localparam int STG_UART = 0;
    localparam int STG_M2   = 1;
    localparam int STG_M1   = 2;
    localparam int STG_VGA  = 3;

endpackage

// File: rtl/sram_bus_mux.sv
// rtl/sram_bus_mux.sv - combinational SRAM port select with parked default
module sram_bus_mux
    import sequencer_pkg::*;
#(
    parameter int N_STAGES = N_STAGES_DEFAULT,
    parameter int OWN_W    = 2
) (
    input  logic [OWN_W-1:0]                owner,
    input  logic                            owner_valid,
    input  logic [N_STAGES*SRAM_ADDR_W-1:0] stage_address,
    input  logic [N_STAGES*SRAM_DATA_W-1:0] stage_write_data,
    input  logic [N_STAGES-1:0]             stage_we_n,
    output logic [SRAM_ADDR_W-1:0]          SRAM_address,
    output logic [SRAM_DATA_W-1:0]          SRAM_write_data,
    output logic                            SRAM_we_n
);

    // Park the bus unless a stage holds ownership; never let a non-owner through
    always_comb begin
        SRAM_address    = PARK_ADDR;
        SRAM_write_data = PARK_DATA;
        SRAM_we_n       = 1'b1;
        if (owner_valid) begin
            SRAM_address    = stage_address[int'(owner)*SRAM_ADDR_W +: SRAM_ADDR_W];
            SRAM_write_data = stage_write_data[int'(owner)*SRAM_DATA_W +: SRAM_DATA_W];
            SRAM_we_n       = stage_we_n[owner];
        end
    end

endmodule

// File: rtl/milestone_sequencer.sv
// rtl/milestone_sequencer.sv - stage scheduler owning the SRAM port (optional STAGE_TIMEOUT_EN watchdog)
module milestone_sequencer
    import sequencer_pkg::*;
#(
    parameter int N_STAGES       = N_STAGES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic                            CLOCK_50_I,
    input  logic                            Reset,
    input  logic                            go,
    input  logic [N_STAGES-1:0]             stage_enable,
    output logic [N_STAGES-1:0]             stage_start,
    input  logic [N_STAGES-1:0]             stage_done,
    input  logic [N_STAGES*SRAM_ADDR_W-1:0] stage_address,
    input  logic [N_STAGES*SRAM_DATA_W-1:0] stage_write_data,
    input  logic [N_STAGES-1:0]             stage_we_n,
    output logic [SRAM_ADDR_W-1:0]          SRAM_address,
    output logic [SRAM_DATA_W-1:0]          SRAM_write_data,
    output logic                            SRAM_we_n,
    output logic [1:0]                      active_stage,
    output logic                            owner_valid,
    output logic                            busy,
    output logic                            all_done,
    output logic                            seq_error
);

    localparam int OWN_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    seq_state_type      state, state_next;
    logic [OWN_W-1:0]   owner, owner_next;
    logic               valid_next;
    logic [N_STAGES-1:0] en_q, en_next;

    logic               first_found, above_found;
    logic [OWN_W-1:0]   first_idx, above_idx;
    logic               done_own;

`ifdef STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               err_q, err_next;
`else
    logic               unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    assign done_own = stage_done[owner];

    // Lowest enabled stage in the incoming mask, and lowest latched stage above the owner
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        above_found = 1'b0;
        above_idx   = '0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if (stage_enable[i]) begin
                first_found = 1'b1;
                first_idx   = OWN_W'(i);
            end
            if (en_q[i] && (i > int'(owner))) begin
                above_found = 1'b1;
                above_idx   = OWN_W'(i);
            end
        end
    end

    // Next-state logic; ownership changes are registered so the mux sees a clean owner
    always_comb begin
        state_next = state;
        owner_next = owner;
        valid_next = owner_valid;
        en_next    = en_q;
`ifdef STAGE_TIMEOUT_EN
        cnt_next   = cnt;
        err_next   = err_q;
`endif
        case (state)
            SEQ_IDLE: begin
                if (go) begin
                    en_next = stage_enable;
`ifdef STAGE_TIMEOUT_EN
                    err_next = 1'b0;
`endif
                    if (first_found) begin
                        owner_next = first_idx;
                        valid_next = 1'b1;
                        state_next = SEQ_START;
                    end else begin
                        state_next = SEQ_DONE;
                    end
                end
            end
            SEQ_START: begin
`ifdef STAGE_TIMEOUT_EN
                cnt_next = '0;
`endif
                if (done_own) begin
                    valid_next = 1'b0;
                    state_next = SEQ_GAP;
                end else begin
                    state_next = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (done_own) begin
                    valid_next = 1'b0;
                    state_next = SEQ_GAP;
                end
`ifdef STAGE_TIMEOUT_EN
                else if (cnt == CNT_LIMIT) begin
                    err_next   = 1'b1;
                    valid_next = 1'b0;
                    state_next = SEQ_DONE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
`endif
            end
            SEQ_GAP: begin
                if (above_found) begin
                    owner_next = above_idx;
                    valid_next = 1'b1;
                    state_next = SEQ_START;
                end else begin
                    state_next = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                state_next = SEQ_IDLE;
            end
            default: begin
                valid_next = 1'b0;
                state_next = SEQ_IDLE;
            end
        endcase
    end

    // State and ownership registers
    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state       <= SEQ_IDLE;
            owner       <= '0;
            owner_valid <= 1'b0;
            en_q        <= '0;
`ifdef STAGE_TIMEOUT_EN
            cnt         <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            owner_valid <= valid_next;
            en_q        <= en_next;
`ifdef STAGE_TIMEOUT_EN
            cnt         <= cnt_next;
            err_q       <= err_next;
`endif
        end
    end

    // Start pulse decoded from the registered owner while in SEQ_START
    always_comb begin
        stage_start = '0;
        if (state == SEQ_START) begin
            stage_start[owner] = 1'b1;
        end
    end

    assign busy         = (state != SEQ_IDLE);
    assign all_done     = (state == SEQ_DONE);
    assign active_stage = owner_valid ? 2'(owner) : 2'd0;

`ifdef STAGE_TIMEOUT_EN
    assign seq_error = err_q;
`else
    assign seq_error = 1'b0;
`endif

    sram_bus_mux #(
        .N_STAGES (N_STAGES),
        .OWN_W    (OWN_W)
    ) u_mux (
        .owner            (owner),
        .owner_valid      (owner_valid),
        .stage_address    (stage_address),
        .stage_write_data (stage_write_data),
        .stage_we_n       (stage_we_n),
        .SRAM_address     (SRAM_address),
        .SRAM_write_data  (SRAM_write_data),
        .SRAM_we_n        (SRAM_we_n)
    );

endmodule
